// File: rtl/pipelined_multiplier_stream.sv
// -----------------------------------------------------------------------------
// pipelined_multiplier_stream
//
// Full-precision A x B multiplier with a valid/ready streaming handshake.
// Each beat carries its own signedness (sgn): 1 multiplies the operands as
// two's complement, 0 multiplies them as unsigned. The pipe is an input
// register (stage 0) followed by OUT_STAGES product registers. The whole pipe
// freezes when the output holds a valid result that the consumer refuses.
// Bubbles are not compacted.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears every valid and data reg
//   in_valid   operand beat present on A/B/sgn
//   in_ready   beat is accepted this cycle (in_valid && in_ready)
//   sgn        1 = signed operands, 0 = unsigned operands
//   A, B       operands
//   out_valid  RES holds a valid product
//   out_ready  consumer takes RES this cycle
//   RES        product, A_WIDTH+B_WIDTH bits
// -----------------------------------------------------------------------------
module pipelined_multiplier_stream #(
  parameter int A_WIDTH    = 32,
  parameter int B_WIDTH    = 32,
  parameter int OUT_STAGES = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       sgn,
  input  logic [A_WIDTH-1:0]         A,
  input  logic [B_WIDTH-1:0]         B,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] RES
);

  localparam int P_W = A_WIDTH + B_WIDTH;

  logic signed [A_WIDTH-1:0] a_p0;
  logic signed [B_WIDTH-1:0] b_p0;
  logic                      sgn_p0;
  logic                      vld_p0;

  // Stage k of the product pipe, k = 1..OUT_STAGES.
  logic signed [P_W-1:0]     prod_pn [1:OUT_STAGES];
  logic                      vld_pn  [1:OUT_STAGES];

  logic                      stall;

  // Extends both operands to the full product width (sign- or zero-extension
  // chosen by s) and multiplies. The low P_W bits of the extended product are
  // exact for both modes, so no overflow handling is needed.
  function automatic logic signed [P_W-1:0] ext_mul(
    input logic signed [A_WIDTH-1:0] a,
    input logic signed [B_WIDTH-1:0] b,
    input logic                      s
  );
    logic signed [P_W-1:0] a_x;
    logic signed [P_W-1:0] b_x;
    a_x = s ? {{B_WIDTH{a[A_WIDTH-1]}}, a} : {{B_WIDTH{1'b0}}, a};
    b_x = s ? {{A_WIDTH{b[B_WIDTH-1]}}, b} : {{A_WIDTH{1'b0}}, b};
    return a_x * b_x;
  endfunction

  // A bubble at the output never stalls, so a bubble arriving there releases
  // any back-pressure on the rest of the pipe.
  assign stall     = vld_pn[OUT_STAGES] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = vld_pn[OUT_STAGES];
  assign RES       = prod_pn[OUT_STAGES];

  // Stage 0: operand capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p0   <= '0;
      b_p0   <= '0;
      sgn_p0 <= 1'b0;
      vld_p0 <= 1'b0;
    end else if (!stall) begin
      a_p0   <= A;
      b_p0   <= B;
      sgn_p0 <= sgn;
      vld_p0 <= in_valid;
    end
  end

  // Stage 1: multiply; stages 2..OUT_STAGES: product delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= OUT_STAGES; k++) begin
        prod_pn[k] <= '0;
        vld_pn[k]  <= 1'b0;
      end
    end else if (!stall) begin
      prod_pn[1] <= ext_mul(a_p0, b_p0, sgn_p0);
      vld_pn[1]  <= vld_p0;
      for (int k = 2; k <= OUT_STAGES; k++) begin
        prod_pn[k] <= prod_pn[k-1];
        vld_pn[k]  <= vld_pn[k-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_multiplier_stream.sv
module tb_pipelined_multiplier_stream;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Default configuration: 32 x 32, OUT_STAGES = 6
  logic        in_valid, sgn, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid;
  logic [63:0] res;

  // Narrow configuration: 8 x 12, OUT_STAGES = 1
  logic        in_valid1, sgn1, out_ready1;
  logic [7:0]  a1;
  logic [11:0] b1;
  logic        in_ready1, out_valid1;
  logic [19:0] res1;

  pipelined_multiplier_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sgn(sgn),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .RES(res)
  );

  pipelined_multiplier_stream #(.A_WIDTH(8), .B_WIDTH(12), .OUT_STAGES(1)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .sgn(sgn1),
    .A(a1), .B(b1), .out_valid(out_valid1), .out_ready(out_ready1), .RES(res1)
  );

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    bit          s;
    logic [7:0]  a;
    logic [11:0] b;
    logic [19:0] exp;
  } vec1_t;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  vec_t        vecs [10];
  vec1_t       vecs1 [4];
  exp_t        sb [$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          delivered = 0;
  bit          lat_chk;
  bit          prev_stall;
  bit          accepted;
  logic [63:0] prev_res;
  logic [63:0] exp_cur;

  function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] ux, uy;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    if (s) return 64'(sx * sy);
    return ux * uy;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input bit v, input bit s, input logic [31:0] x, input logic [31:0] y,
                       input bit ord);
    in_valid  = v;
    sgn       = s;
    a         = x;
    b         = y;
    out_ready = ord;
    exp_cur   = ref_mul(s, x, y);
  endtask

  // Entered just after a rising edge with inputs driven; checks the cycle at
  // the falling edge and returns just after the next rising edge.
  task automatic cycle_end();
    exp_t e;
    @(negedge clk);
    chk("in_ready", in_ready, !(out_valid && !out_ready));
    if (prev_stall) begin
      chk("stall_res_stable", res, prev_res);
      chk("stall_valid_stable", out_valid, 1);
    end
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      delivered++;
      if (sb.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("res", res, e.res);
        if (lat_chk) chk("latency", cyc - e.cyc, 7);
      end
    end
    if (accepted) sb.push_back('{exp_cur, cyc});
    prev_stall = out_valid && !out_ready;
    prev_res   = res;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles carry nonzero junk operands so bubbles are not all-zero.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 32'hA5A5_0003, 32'h0000_0101, 1'b1);
      cycle_end();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int idx;
    int stall_left;
    bit ord;

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[3] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[4] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[7] = '{1'b1, 32'h0000_0003, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[8] = '{1'b0, 32'h0000_1234, 32'h0001_0000, 64'h0000_0000_1234_0000};
    vecs[9] = '{1'b1, 32'h0000_0000, 32'h8000_0000, 64'h0000_0000_0000_0000};

    vecs1[0] = '{1'b1, 8'h80, 12'h7FF, 20'hC0080};
    vecs1[1] = '{1'b0, 8'h80, 12'h7FF, 20'h3FF80};
    vecs1[2] = '{1'b1, 8'hFF, 12'h002, 20'hFFFFE};
    vecs1[3] = '{1'b0, 8'hFF, 12'hFFF, 20'hFEF01};

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    in_valid1 = 1'b0; sgn1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b1;
    prev_stall = 1'b0;
    prev_res   = '0;
    lat_chk    = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_w_out_valid", out_valid1, 0);
    chk("rst_w_res", res1, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Single unsigned beat: latency and no early out_valid
    drive(vecs[0].s, vecs[0].s, vecs[0].a, vecs[0].b, 1'b1);
    drive(1'b1, vecs[0].s, vecs[0].a, vecs[0].b, 1'b1);
    cycle_end();
    idle(9);

    // Directed table, back-to-back
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].s, vecs[i].a, vecs[i].b, 1'b1);
      chk("table_model", exp_cur, vecs[i].exp);
      cycle_end();
    end
    idle(8);

    // 20-beat stream with alternating signedness
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, bit'(i % 2), $urandom, $urandom, 1'b1);
      cycle_end();
    end
    idle(8);

    // Back-pressure: 5 stalled cycles once the first result shows up
    lat_chk    = 1'b0;
    delivered  = 0;
    idx        = 0;
    stall_left = 5;
    for (int guard = 0; guard < 100 && (idx < 10 || sb.size() > 0); guard++) begin
      ord = 1'b1;
      if (out_valid && stall_left > 0) begin
        ord = 1'b0;
        stall_left--;
      end
      if (idx < 10) drive(1'b1, vecs[idx].s, vecs[idx].a, vecs[idx].b, ord);
      else          drive(1'b0, 1'b0, 32'hA5A5_0003, 32'h0000_0101, ord);
      cycle_end();
      if (accepted) idx++;
    end
    chk("bp_drained", sb.size(), 0);
    chk("bp_delivered", delivered, 10);
    chk("bp_stalls_used", stall_left, 0);
    idle(2);

    // Bubbles: in_valid 1,0,0,1
    lat_chk = 1'b1;
    drive(1'b1, vecs[2].s, vecs[2].a, vecs[2].b, 1'b1);
    cycle_end();
    idle(2);
    drive(1'b1, vecs[4].s, vecs[4].a, vecs[4].b, 1'b1);
    cycle_end();
    idle(9);

    // Reset with 4 beats in flight
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vecs[i+5].s, vecs[i+5].a, vecs[i+5].b, 1'b1);
      cycle_end();
    end
    drive(1'b0, 1'b0, 32'hA5A5_0003, 32'h0000_0101, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_res", res, 0);
    chk("midrst_in_ready", in_ready, 1);
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    delivered = 0;
    idle(12);
    chk("post_reset_delivered", delivered, 0);

    // Narrow configuration: result visible two cycles after the beat is driven
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        in_valid1 = 1'b1; sgn1 = vecs1[k].s; a1 = vecs1[k].a; b1 = vecs1[k].b;
      end else begin
        in_valid1 = 1'b0; sgn1 = 1'b0; a1 = 8'h5A; b1 = 12'h0C3;
      end
      @(negedge clk);
      if (k < 2) begin
        chk("w_valid_early", out_valid1, 0);
      end else begin
        chk("w_valid", out_valid1, 1);
        chk("w_res", res1, vecs1[k-2].exp);
      end
      @(posedge clk);
      #1;
    end
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("w_valid_after", out_valid1, 0);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
